// File: rtl/ysyx_key_lookup.sv
// Registered, writable key/value lookup table with a
// valid/ready lookup port and a saturating miss counter.
module ysyx_key_lookup #(
  parameter int NR_KEY      = 8,
  parameter int KEY_LEN     = 8,
  parameter int DATA_LEN    = 32,
  parameter int MODE        = 0,
  parameter int HAS_DEFAULT = 1,
  parameter int CNT_LEN     = 16,
  localparam int IDX_LEN    = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                wr_vld,
  input  logic                clr_all,
  input  logic [DATA_LEN-1:0] default_out,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_LEN-1:0]  in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_hit,
  output logic                out_multi,
  output logic [IDX_LEN-1:0]  out_idx,
  output logic [CNT_LEN-1:0]  miss_cnt
);

  localparam logic [IDX_LEN:0] NrKeyW = NR_KEY[IDX_LEN:0];
  localparam logic [NR_KEY-1:0] One = {{(NR_KEY-1){1'b0}}, 1'b1};

  logic [NR_KEY-1:0]   vld_q;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];

  logic                out_valid_q;
  logic [DATA_LEN-1:0] out_data_q, out_data_d;
  logic                out_hit_q, out_hit_d;
  logic                out_multi_q, out_multi_d;
  logic [IDX_LEN-1:0]  out_idx_q, out_idx_d;
  logic [CNT_LEN-1:0]  miss_cnt_q, miss_cnt_d;

  logic [NR_KEY-1:0]   hit_vec;
  logic [DATA_LEN-1:0] or_data;
  logic [DATA_LEN-1:0] pri_data;
  logic                accept;
  logic                wr_ok;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign wr_ok    = wr_en && ({1'b0, wr_idx} < NrKeyW);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (clr_all) begin
      vld_q <= '0;
    end else if (wr_ok) begin
      vld_q[wr_idx]  <= wr_vld;
      key_q[wr_idx]  <= wr_key;
      data_q[wr_idx] <= wr_data;
    end
  end

  // Descending scan leaves the lowest hit in idx/pri_data.
  always_comb begin
    hit_vec  = '0;
    or_data  = '0;
    pri_data = '0;
    out_idx_d = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      hit_vec[i] = vld_q[i] && (key_q[i] == in_key);
      or_data = or_data | ({DATA_LEN{hit_vec[i]}} & data_q[i]);
      if (hit_vec[i]) begin
        out_idx_d = i[IDX_LEN-1:0];
        pri_data  = data_q[i];
      end
    end
    out_hit_d   = |hit_vec;
    out_multi_d = |(hit_vec & (hit_vec - One));
    if (out_hit_d)
      out_data_d = (MODE == 1) ? pri_data : or_data;
    else
      out_data_d = (HAS_DEFAULT != 0) ? default_out : '0;
    miss_cnt_d = miss_cnt_q;
    if (accept && !out_hit_d && (miss_cnt_q != {CNT_LEN{1'b1}}))
      miss_cnt_d = miss_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_hit_q   <= 1'b0;
      out_multi_q <= 1'b0;
      out_idx_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        out_hit_q   <= out_hit_d;
        out_multi_q <= out_multi_d;
        out_idx_q   <= out_idx_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_hit   = out_hit_q;
  assign out_multi = out_multi_q;
  assign out_idx   = out_idx_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_ysyx_key_lookup.sv
// Scoreboard bench: an OR-merge/16-bit-counter instance and a
// priority/4-bit-counter instance share one stimulus stream.
module tb_ysyx_key_lookup;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [7:0]  wr_key;
  logic [31:0] wr_data;
  logic        wr_vld;
  logic        clr_all;
  logic [31:0] default_out;
  logic        in_valid;
  logic [7:0]  in_key;
  logic        out_ready;

  logic        a_in_ready, a_valid, a_hit, a_multi;
  logic [31:0] a_data;
  logic [2:0]  a_idx;
  logic [15:0] a_cnt;
  logic        b_in_ready, b_valid, b_hit, b_multi;
  logic [31:0] b_data;
  logic [2:0]  b_idx;
  logic [3:0]  b_cnt;

  ysyx_key_lookup #(.MODE(0), .CNT_LEN(16)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_key(wr_key), .wr_data(wr_data), .wr_vld(wr_vld),
    .clr_all(clr_all), .default_out(default_out),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_key(in_key),
    .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data),
    .out_hit(a_hit), .out_multi(a_multi), .out_idx(a_idx),
    .miss_cnt(a_cnt)
  );

  ysyx_key_lookup #(.MODE(1), .CNT_LEN(4)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_key(wr_key), .wr_data(wr_data), .wr_vld(wr_vld),
    .clr_all(clr_all), .default_out(default_out),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_key(in_key),
    .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data),
    .out_hit(b_hit), .out_multi(b_multi), .out_idx(b_idx),
    .miss_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s act=%h exp=%h", name, act, exp);
  endtask

  function automatic logic [63:0] obs_a();
    return {11'b0, a_data, a_hit, a_multi, a_idx, a_cnt};
  endfunction

  function automatic logic [63:0] obs_b();
    return {23'b0, b_data, b_hit, b_multi, b_idx, b_cnt};
  endfunction

  initial begin : mon_a
    logic [63:0] prev;
    logic held;
    held = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || a_valid !== 1'b1) begin
        held = 1'b0;
      end else begin
        if (held) chk("holdA", obs_a(), prev);
        if (out_ready !== 1'b1) begin
          chk("in_readyA", {63'b0, a_in_ready}, 64'd0);
          held = 1'b1;
          prev = obs_a();
        end else begin
          held = 1'b0;
          if (qa.size() == 0) chk("unexpectedA", obs_a(), 64'hFFFF);
          else chk("resultA", obs_a(), qa.pop_front());
        end
      end
    end
  end

  initial begin : mon_b
    logic [63:0] prev;
    logic held;
    held = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || b_valid !== 1'b1) begin
        held = 1'b0;
      end else begin
        if (held) chk("holdB", obs_b(), prev);
        if (out_ready !== 1'b1) begin
          chk("in_readyB", {63'b0, b_in_ready}, 64'd0);
          held = 1'b1;
          prev = obs_b();
        end else begin
          held = 1'b0;
          if (qb.size() == 0) chk("unexpectedB", obs_b(), 64'hFFFF);
          else chk("resultB", obs_b(), qb.pop_front());
        end
      end
    end
  end

  task automatic write_entry(input logic [2:0] idx, input logic [7:0] k,
                             input logic [31:0] d, input logic v);
    wr_en = 1'b1; wr_idx = idx; wr_key = k; wr_data = d; wr_vld = v;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] k, input logic [31:0] da,
                        input logic [31:0] db, input logic h,
                        input logic m, input logic [2:0] idx);
    logic done;
    done = 1'b0;
    in_valid = 1'b1;
    in_key   = k;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (a_in_ready === 1'b1) begin
        if (!h) begin
          cnt_a++;
          if (cnt_b < 15) cnt_b++;
        end
        qa.push_back({11'b0, da, h, m, idx, cnt_a[15:0]});
        qb.push_back({23'b0, db, h, m, idx, cnt_b[3:0]});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic miss(input logic [7:0] k);
    lookup(k, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_key = '0;
    wr_data = '0; wr_vld = 1'b0; clr_all = 1'b0;
    default_out = 32'hDEADBEEF; in_valid = 1'b0; in_key = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rstA", {a_valid, a_data, a_hit, a_multi, a_idx, a_cnt}, 64'd0);
    chk("rstB", {b_valid, b_data, b_hit, b_multi, b_idx, b_cnt}, 64'd0);
    rst = 1'b0;

    miss(8'h00);

    write_entry(3'd3, 8'h12, 32'hA5A50001, 1'b1);
    lookup(8'h12, 32'hA5A50001, 32'hA5A50001, 1'b1, 1'b0, 3'd3);

    write_entry(3'd1, 8'h40, 32'h000000F0, 1'b1);
    write_entry(3'd5, 8'h40, 32'h0000000F, 1'b1);
    lookup(8'h40, 32'h000000FF, 32'h000000F0, 1'b1, 1'b1, 3'd1);

    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    lookup(8'h12, 32'hA5A50001, 32'hA5A50001, 1'b1, 1'b0, 3'd3);
    fork
      begin
        lookup(8'h40, 32'h000000FF, 32'h000000F0, 1'b1, 1'b1, 3'd1);
        miss(8'h99);
        lookup(8'h12, 32'hA5A50001, 32'hA5A50001, 1'b1, 1'b0, 3'd3);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join

    wr_en = 1'b1; wr_idx = 3'd0; wr_key = 8'h77;
    wr_data = 32'h1; wr_vld = 1'b1;
    miss(8'h77);
    wr_en = 1'b0;
    lookup(8'h77, 32'h1, 32'h1, 1'b1, 1'b0, 3'd0);

    clr_all = 1'b1;
    write_entry(3'd2, 8'h55, 32'h9, 1'b1);
    clr_all = 1'b0;
    miss(8'h12);
    miss(8'h40);
    miss(8'h55);
    miss(8'h77);

    for (int i = 0; i < 20; i++) miss(8'h33);
    write_entry(3'd4, 8'h21, 32'h123, 1'b1);
    lookup(8'h21, 32'h123, 32'h123, 1'b1, 1'b0, 3'd4);
    write_entry(3'd4, 8'h21, 32'h123, 1'b0);
    miss(8'h21);

    repeat (3) @(posedge clk);
    #1;
    chk("drainA", 64'(qa.size()), 64'd0);
    chk("drainB", 64'(qb.size()), 64'd0);
    chk("satB", {60'd0, b_cnt}, 64'd15);
    chk("cntA", {48'd0, a_cnt}, 64'd28);

    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2A", {a_valid, a_data, a_hit, a_multi, a_idx, a_cnt}, 64'd0);
    chk("rst2B", {b_valid, b_data, b_hit, b_multi, b_idx, b_cnt}, 64'd0);
    rst = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    miss(8'h12);
    repeat (3) @(posedge clk);
    #1;
    chk("endA", 64'(qa.size()), 64'd0);
    chk("endB", 64'(qb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
